painel_scan_ctrl: RTL and testbench

PAINEL_SCAN_CTRL -- requirements
Module: painel_scan_ctrl

---
 rtl/painel_scan_if.sv | 29 ++
 rtl/painel_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_painel_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/painel_scan_if.sv
// ---------------------------------------------------------------------------
// painel_scan_if
// Write / swap bus between a pattern writer and painel_scan_ctrl.
//   wrValid     writer offers one column of shadow-buffer data
//   wrReady     controller accepts the offered write this cycle
//   wrCol       column index 0..4 (5..7 are accepted and discarded)
//   wrData      row pattern for the column, bit0 = top row
//   swapReq     one-cycle pulse asking for the shadow buffer to go live
//   swapPending swap requested but not yet applied
// Modports: master = writer side, slave = controller side.
// ---------------------------------------------------------------------------
interface painel_scan_if;
  logic       wrValid;
  logic       wrReady;
  logic [2:0] wrCol;
  logic [6:0] wrData;
  logic       swapReq;
  logic       swapPending;

  modport master (
    output wrValid, wrCol, wrData, swapReq,
    input  wrReady, swapPending
  );

  modport slave (
    input  wrValid, wrCol, wrData, swapReq,
    output wrReady, swapPending
  );
endinterface

// File: rtl/painel_scan_ctrl.sv
// ---------------------------------------------------------------------------
// painel_scan_ctrl
// Column-multiplexed scan controller for a 5x7 LED panel with a double
// buffer.  Each column is driven for DIV clocks, followed by one blank clock
// to stop ghosting.  A writer fills the shadow buffer at any time.  A
// requested swap is applied only at the frame wrap, or at once when idle,
// so the displayed frame never tears.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rstN      asynchronous active-low reset
//   enable    1 = scan; 0 = finish the current frame, then idle
//   wr        painel_scan_if.slave write/swap bus
//   colSel    one-hot column drive (bit n = column n), 0 while blank/idle
//   rowData   row pattern for the driven column, 0 while colSel is 0
//   frameEnd  one-cycle pulse in the cycle after column 4's blank
//
// Parameters:
//   DIV            clocks each column is driven (2..65535)
//   SCROLL_FRAMES  frames per scroll step (scroll build only)
//
// Optional feature macro: PAINEL_SCROLL_EN.  When defined, a scroll offset
// (0..4) advances every SCROLL_FRAMES frames, and column c shows
// live[(c + offset) mod 5].
// ---------------------------------------------------------------------------
module painel_scan_ctrl #(
  parameter int unsigned DIV           = 1000,
  parameter int unsigned SCROLL_FRAMES = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              enable,
  painel_scan_if.slave      wr,
  output logic [4:0]        colSel,
  output logic [6:0]        rowData,
  output logic              frameEnd
);

  // Elaboration-time guard against parameter values the counters cannot hold
  if ((DIV < 2) || (DIV > 65535) || (SCROLL_FRAMES < 1)) begin : g_bad_param
    $error("painel_scan_ctrl: DIV must be 2..65535 and SCROLL_FRAMES >= 1");
  end

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [2:0]  COL_LAST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  col;
  logic [2:0]  col_nx;
  logic [15:0] div_cnt;
  logic [15:0] div_nx;
  logic        frame_end_nx;

  logic [6:0]  live_buf   [5];
  logic [6:0]  shadow_buf [5];
  logic [6:0]  live_nx    [5];

  logic        swap_pend;
  logic        pend_nx;
  logic        apply_swap;
  logic        wr_ready;
  logic        ready_nx;
  logic        wr_fire;

  logic [2:0]  row_idx_nx;
  logic [4:0]  col_sel_nx;
  logic [6:0]  row_nx;

  assign wr.wrReady     = wr_ready;
  assign wr.swapPending = swap_pend;

  // Scan sequencer: next state, column and divider
  always_comb begin
    state_nx     = state;
    col_nx       = col;
    div_nx       = div_cnt;
    frame_end_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nx = ST_DRIVE;
          col_nx   = 3'd0;
          div_nx   = 16'd0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (div_cnt == DIV_LAST) begin
          state_nx = ST_BLANK;
          div_nx   = 16'd0;
        end else begin
          div_nx   = div_cnt + 16'd1;
        end
      end
      ST_BLANK: begin
        div_nx = 16'd0;
        if (col == COL_LAST) begin
          // Frame wrap: enable is only looked at here, so frames never truncate
          frame_end_nx = 1'b1;
          col_nx       = 3'd0;
          state_nx     = enable ? ST_DRIVE : ST_IDLE;
        end else begin
          col_nx       = col + 3'd1;
          state_nx     = ST_DRIVE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        col_nx   = 3'd0;
        div_nx   = 16'd0;
      end
    endcase
  end

  // State register for the scan sequencer
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= ST_IDLE;
      col     <= 3'd0;
      div_cnt <= 16'd0;
    end else begin
      state   <= state_nx;
      col     <= col_nx;
      div_cnt <= div_nx;
    end
  end

  // Swap/write control.  The swap edge is the one leaving column 4's blank
  // (or any idle cycle), so the first cycle of the new frame already shows
  // the new buffer.  wrReady is registered and low exactly in that cycle, so
  // a write offered alongside the swap lands in the shadow one cycle later.
  always_comb begin
    apply_swap = swap_pend &&
                 ((state == ST_IDLE) || ((state == ST_BLANK) && (col == COL_LAST)));
    // A request arriving in the swap cycle itself stays pending for next frame
    pend_nx    = wr.swapReq || (swap_pend && !apply_swap);
    ready_nx   = !(pend_nx &&
                   ((state_nx == ST_IDLE) ||
                    ((state_nx == ST_BLANK) && (col_nx == COL_LAST))));
    wr_fire    = wr.wrValid && wr_ready && (wr.wrCol <= COL_LAST);
    for (int i = 0; i < 5; i++) begin
      live_nx[i] = apply_swap ? shadow_buf[i] : live_buf[i];
    end
  end

  // Buffer storage, pending flag and write-ready register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 5; i++) begin
        live_buf[i]   <= 7'd0;
        shadow_buf[i] <= 7'd0;
      end
      swap_pend <= 1'b0;
      wr_ready  <= 1'b1;
    end else begin
      for (int i = 0; i < 5; i++) begin
        live_buf[i] <= live_nx[i];
      end
      if (wr_fire) begin
        shadow_buf[wr.wrCol] <= wr.wrData;
      end else begin
        shadow_buf <= shadow_buf;
      end
      swap_pend <= pend_nx;
      wr_ready  <= ready_nx;
    end
  end

`ifdef PAINEL_SCROLL_EN
  localparam logic [15:0] FRAMES_LAST = 16'(SCROLL_FRAMES - 1);

  logic [2:0]  offset;
  logic [2:0]  offset_nx;
  logic [15:0] frame_cnt;
  logic [15:0] frame_cnt_nx;

  // Column index plus offset, folded back into 0..4
  function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 4'd5) begin
      sum = sum - 4'd5;
    end else begin
      sum = sum;
    end
    return sum[2:0];
  endfunction

  // Scroll offset advances on the same edge as the frame wrap
  always_comb begin
    offset_nx    = offset;
    frame_cnt_nx = frame_cnt;
    if (frame_end_nx) begin
      if (frame_cnt == FRAMES_LAST) begin
        frame_cnt_nx = 16'd0;
        offset_nx    = (offset == COL_LAST) ? 3'd0 : (offset + 3'd1);
      end else begin
        frame_cnt_nx = frame_cnt + 16'd1;
      end
    end else begin
      frame_cnt_nx = frame_cnt;
    end
    row_idx_nx = mod5_add(col_nx, offset_nx);
  end

  // Scroll offset and frame counter registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      offset    <= 3'd0;
      frame_cnt <= 16'd0;
    end else begin
      offset    <= offset_nx;
      frame_cnt <= frame_cnt_nx;
    end
  end
`else
  // Without scrolling each column shows its own buffer entry
  always_comb begin
    row_idx_nx = col_nx;
  end
`endif

  // Next-cycle panel drive, decoded from the next state
  always_comb begin
    if (state_nx == ST_DRIVE) begin
      col_sel_nx = 5'd1 << col_nx;
      row_nx     = live_nx[row_idx_nx];
    end else begin
      col_sel_nx = 5'd0;
      row_nx     = 7'd0;
    end
  end

  // Registered panel outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      colSel   <= 5'd0;
      rowData  <= 7'd0;
      frameEnd <= 1'b0;
    end else begin
      colSel   <= col_sel_nx;
      rowData  <= row_nx;
      frameEnd <= frame_end_nx;
    end
  end

endmodule

// File: tb/tb_painel_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_painel_scan_ctrl
// Self-checking bench for painel_scan_ctrl with DIV=4 (25-cycle frames).
// A behavioural model, written as a position-in-frame counter, pushes the
// expected output vector into a scoreboard queue at every rising edge; the
// checker pops and compares on the falling edge.  Directed checks cover the
// reset state, frame period, double buffering and scroll behaviour.
// ---------------------------------------------------------------------------
module tb_painel_scan_ctrl;
  localparam int DIV = 4;
  localparam int SF  = 2;
  localparam int FP  = 5 * (DIV + 1);

  logic       clk;
  logic       rstN;
  logic       enable;
  logic [4:0] colSel;
  logic [6:0] rowData;
  logic       frameEnd;

  painel_scan_if bus ();

  painel_scan_ctrl #(.DIV(DIV), .SCROLL_FRAMES(SF)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .enable   (enable),
    .wr       (bus),
    .colSel   (colSel),
    .rowData  (rowData),
    .frameEnd (frameEnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Single comparison point: counts and reports
  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_run;
  int         m_pos;
  logic [6:0] m_live   [5];
  logic [6:0] m_shadow [5];
  bit         m_pend;
  bit         m_fe;
  int         m_off;
  int         m_fcnt;
  logic [14:0] sb [$];

  function automatic logic [14:0] exp_vec();
    int c, ph;
    bit drive, rdy;
    logic [4:0] cs;
    logic [6:0] rd;
    c     = m_pos / (DIV + 1);
    ph    = m_pos % (DIV + 1);
    drive = m_run && (ph < DIV);
    cs    = drive ? (5'd1 << c) : 5'd0;
    rd    = drive ? m_live[(c + m_off) % 5] : 7'd0;
    rdy   = !(m_pend && (!m_run || (m_pos == FP - 1)));
    return {m_fe, rdy, m_pend, cs, rd};
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_pend = 0; m_fe = 0; m_off = 0; m_fcnt = 0;
    for (int i = 0; i < 5; i++) begin
      m_live[i] = 7'd0;
      m_shadow[i] = 7'd0;
    end
  endtask

  initial begin
    bit last, apply, accept;
    model_reset();
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        model_reset();
        sb.delete();
        if (clk) sb.push_back(exp_vec());
      end else begin
        last   = m_run && (m_pos == FP - 1);
        apply  = m_pend && (!m_run || last);
        accept = bus.wrValid && !apply && (bus.wrCol <= 3'd4);
        m_fe   = last;
        if (apply) for (int i = 0; i < 5; i++) m_live[i] = m_shadow[i];
        if (accept) m_shadow[bus.wrCol] = bus.wrData;
        m_pend = bus.swapReq || (m_pend && !apply);
`ifdef PAINEL_SCROLL_EN
        if (m_fe) begin
          m_fcnt++;
          if (m_fcnt == SF) begin
            m_fcnt = 0;
            m_off  = (m_off + 1) % 5;
          end
        end
`endif
        if (!m_run) begin
          if (enable) begin m_run = 1; m_pos = 0; end
        end else if (last) begin
          m_pos = 0;
          m_run = enable;
        end else begin
          m_pos++;
        end
        sb.push_back(exp_vec());
      end
    end
  end

  // Scoreboard checker on the falling edge
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_eq("cycle", {frameEnd, bus.wrReady, bus.swapPending, colSel, rowData}, e);
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic wr_col(input logic [2:0] c, input logic [6:0] d);
    bit done = 0;
    bit rdy;
    bus.wrValid = 1'b1; bus.wrCol = c; bus.wrData = d;
    for (int i = 0; i < 100; i++) begin
      rdy = bus.wrReady;
      @(negedge clk);
      if (rdy) begin done = 1; break; end
    end
    bus.wrValid = 1'b0;
    if (!done) chk_eq("wr_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_swap();
    bus.swapReq = 1'b1;
    @(negedge clk);
    bus.swapReq = 1'b0;
  endtask

  task automatic wait_fe(output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (frameEnd) begin seen = 1; break; end
    end
    if (!seen) chk_eq("fe_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rdy_low();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.wrReady) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) chk_eq("rdy_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_col(input logic [4:0] cs);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (colSel == cs) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) chk_eq("col_timeout", 64'd0, 64'd1);
  endtask

  // Sample the row pattern of each column, starting at a frame's first cycle
  task automatic grab_rows(output logic [34:0] r);
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[k*7 +: 7] = rowData;
      repeat (DIV + 1) @(negedge clk);
    end
  endtask

  function automatic logic [34:0] pack_rows(input logic [6:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [34:0] r;
    rstN = 1'b0; enable = 1'b0;
    bus.wrValid = 1'b0; bus.wrCol = 3'd0; bus.wrData = 7'd0; bus.swapReq = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_colSel",   colSel,          0);
    chk_eq("rst_rowData",  rowData,         0);
    chk_eq("rst_frameEnd", frameEnd,        0);
    chk_eq("rst_wrReady",  bus.wrReady,     1);
    chk_eq("rst_pending",  bus.swapPending, 0);
    rstN = 1'b1;

`ifdef PAINEL_SCROLL_EN
    // Scroll: only column-0 data lit; offset steps every SF frames
    wr_col(3'd0, 7'h7F);
    pulse_swap();
    @(negedge clk);
    enable = 1'b1;
    wait_fe(n);
    for (int f = 1; f <= 4; f++) begin
      int lit;
      lit = (f <= 1) ? 0 : (f <= 3) ? 4 : 3;
      grab_rows(r);
      chk_eq("scroll_frame", r, 35'h7F << (7 * lit));
    end
`else
    // Frame period with DIV=4
    enable = 1'b1;
    wait_fe(n);
    wait_fe(n);
    chk_eq("fe_period", n, FP);
    chk_eq("fe_col0",   colSel, 5'b00001);

    // Fill shadow mid-frame, swap, check it goes live only next frame
    repeat (7) @(negedge clk);
    for (int k = 0; k < 5; k++) wr_col(3'(k), 7'h01 << k);
    pulse_swap();
    chk_eq("swap_pending", bus.swapPending, 1);
    chk_eq("live_old_row", rowData, 0);
    wait_fe(n);
    grab_rows(r);
    chk_eq("rows_new", r, pack_rows(7'h01, 7'h02, 7'h04, 7'h08, 7'h10));

    // Write offered in the swap cycle is held and lands after the copy
    pulse_swap();
    wait_rdy_low();
    wr_col(3'd1, 7'h55);
    chk_eq("held_pending", bus.swapPending, 0);
    wait_fe(n);
    grab_rows(r);
    chk_eq("rows_old", r, pack_rows(7'h01, 7'h02, 7'h04, 7'h08, 7'h10));
    pulse_swap();
    wait_fe(n);
    grab_rows(r);
    chk_eq("rows_held", r, pack_rows(7'h01, 7'h55, 7'h04, 7'h08, 7'h10));

    // Illegal column is discarded
    wr_col(3'd6, 7'h7F);
    pulse_swap();
    wait_fe(n);
    grab_rows(r);
    chk_eq("rows_illegal", r, pack_rows(7'h01, 7'h55, 7'h04, 7'h08, 7'h10));

    // enable drops in column 2: frame completes, then idle
    repeat (11) @(negedge clk);
    chk_eq("col2_drive", colSel, 5'b00100);
    enable = 1'b0;
    wait_fe(n);
    chk_eq("drain_len", n, FP - 11);
    chk_eq("idle_col",  colSel, 0);
    repeat (3) @(negedge clk);
    chk_eq("idle_hold", colSel, 0);

    // Swap while idle applies at once
    wr_col(3'd2, 7'h3C);
    pulse_swap();
    chk_eq("idle_rdy_low", bus.wrReady, 0);
    @(negedge clk);
    chk_eq("idle_pend_clr", bus.swapPending, 0);
    enable = 1'b1;
    @(negedge clk);
    grab_rows(r);
    chk_eq("rows_idle_swap", r, pack_rows(7'h01, 7'h55, 7'h3C, 7'h08, 7'h10));

    // Reset mid-frame while column 2 is driven and a swap is pending
    pulse_swap();
    wait_col(5'b00100);
    #2 rstN = 1'b0;
    #1;
    chk_eq("mid_rst_col",  colSel,          0);
    chk_eq("mid_rst_row",  rowData,         0);
    chk_eq("mid_rst_pend", bus.swapPending, 0);
    chk_eq("mid_rst_rdy",  bus.wrReady,     1);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    chk_eq("restart_col0", colSel, 5'b00001);
    grab_rows(r);
    chk_eq("rows_after_rst", r, 35'd0);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
